// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants for the UART peripheral slice: data width, MMIO
// register addresses and the default receive FIFO depth. Imported by the
// receive FIFO, its storage array and its bus interface.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [31:0] UART_TXD = 32'h4000_0018;
  localparam logic [31:0] UART_RXD = 32'h4000_001C;
  localparam logic [31:0] UART_CON = 32'h4000_0020;

  localparam int UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Bundles the receiver-side and CPU-side signals of the receive FIFO.
//   master : drives rx_valid, rx_byte, pop, clr_overflow;
//            observes rd_data, empty, full, level, overflow, irq
//   slave  : the FIFO itself (mirror image of master)
// DEPTH must match the DEPTH of the attached uart_rx_fifo so that level
// has the right width.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH
);

  localparam int AW = $clog2(DEPTH);

  logic                   rx_valid;
  logic [UART_DATA_W-1:0] rx_byte;
  logic                   pop;
  logic                   clr_overflow;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   empty;
  logic                   full;
  logic [AW:0]            level;
  logic                   overflow;
  logic                   irq;

  modport master (
    output rx_valid, rx_byte, pop, clr_overflow,
    input  rd_data, empty, full, level, overflow, irq
  );

  modport slave (
    input  rx_valid, rx_byte, pop, clr_overflow,
    output rd_data, empty, full, level, overflow, irq
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem
// DEPTH x UART_DATA_W register array backing the receive FIFO.
//   clk    : write clock
//   wrEn   : write strobe; wrData lands in mem[wrAddr] on the rising edge
//   wrAddr : write address
//   wrData : write data
//   rdAddr : read address
//   rdData : asynchronous read of mem[rdAddr]
// The array has no reset; the FIFO masks its output while empty, so stale
// contents are never visible.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       wrEn,
  input  logic [$clog2(DEPTH)-1:0]   wrAddr,
  input  logic [UART_DATA_W-1:0]     wrData,
  input  logic [$clog2(DEPTH)-1:0]   rdAddr,
  output logic [UART_DATA_W-1:0]     rdData
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte FIFO between the uart_rx receiver and the UART MMIO
// block. Each one-cycle rx_valid strobe stores rx_byte; the oldest byte is
// presented first-word-fall-through on rd_data for the CPU data-register
// read, and pop removes it.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : uart_rx_fifo_if.slave
//          rx_valid/rx_byte  byte strobe and data from the receiver
//          pop               CPU consumed the head byte
//          clr_overflow      clears the sticky overflow flag
//          rd_data           head byte, 8'h00 while empty
//          empty/full/level  occupancy, derived from the level counter
//          overflow          sticky: a byte was dropped while full
//          irq               watermark flag (level >= THRESH)
// Optional build macro UART_RX_FIFO_THRESH_EN enables the registered
// watermark irq; without it irq is tied low and THRESH is unused.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int THRESH = 12
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

  logic [AW-1:0]          wrPtr;
  logic [AW-1:0]          rdPtr;
  logic [AW:0]            levelReg;
  logic [AW:0]            nextLevel;
  logic                   overflowReg;
  logic                   isEmpty;
  logic                   isFull;
  logic                   popEff;
  logic                   push;
  logic                   drop;
  logic [UART_DATA_W-1:0] memRdData;

  assign isEmpty = (levelReg == '0);
  assign isFull  = (levelReg == FullLevel);

  // A pop while empty is ignored; a push while full is only accepted when
  // a real pop frees the head slot in the same cycle.
  assign popEff = bus.pop & ~isEmpty;
  assign push   = bus.rx_valid & (~isFull | popEff);
  assign drop   = bus.rx_valid & isFull & ~popEff;

  always_comb begin
    nextLevel = levelReg;
    unique case ({push, popEff})
      2'b10:   nextLevel = levelReg + 1'b1;
      2'b01:   nextLevel = levelReg - 1'b1;
      default: nextLevel = levelReg;
    endcase
  end

  // Set of overflow beats a same-cycle clear so a drop is never missed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      levelReg    <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popEff) begin
        rdPtr <= rdPtr + 1'b1;
      end
      levelReg <= nextLevel;
      if (drop) begin
        overflowReg <= 1'b1;
      end else if (bus.clr_overflow) begin
        overflowReg <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) uMem (
    .clk    (clk),
    .wrEn   (push & ~rst),
    .wrAddr (wrPtr),
    .wrData (bus.rx_byte),
    .rdAddr (rdPtr),
    .rdData (memRdData)
  );

  assign bus.rd_data  = isEmpty ? '0 : memRdData;
  assign bus.empty    = isEmpty;
  assign bus.full     = isFull;
  assign bus.level    = levelReg;
  assign bus.overflow = overflowReg;

`ifdef UART_RX_FIFO_THRESH_EN
  localparam logic [AW:0] ThreshLevel = (AW+1)'(THRESH);

  logic irqReg;

  // Compare against the post-edge level so irq changes on the same edge
  // the level crosses the watermark.
  always_ff @(posedge clk) begin
    if (rst) begin
      irqReg <= 1'b0;
    end else begin
      irqReg <= (nextLevel >= ThreshLevel);
    end
  end

  assign bus.irq = irqReg;
`else
  // THRESH only feeds an elaboration-time range constant here, which
  // folds away; irq is a constant zero.
  localparam logic ThreshInRange = (THRESH >= 1) && (THRESH <= DEPTH);

  assign bus.irq = 1'b0 & ThreshInRange;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. A queue-based reference model
// tracks the stored bytes and the sticky overflow flag; every cycle the
// DUT outputs are compared against it with immediate assertions.
// Define UART_RX_FIFO_THRESH_EN for both bench and RTL to exercise irq.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 12;
  localparam int AW     = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .THRESH (THRESH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] model[$];
  logic       modelOvf = 1'b0;

  // Compare every DUT output against the reference model.
  task automatic checkOutput(input string tag);
    logic [AW:0] expLevel;
    logic [7:0]  expData;
    logic        expIrq;
    expLevel = (AW+1)'(model.size());
    expData  = (model.size() > 0) ? model[0] : 8'h00;
`ifdef UART_RX_FIFO_THRESH_EN
    expIrq   = (model.size() >= THRESH);
`else
    expIrq   = 1'b0;
`endif
    testsRun++;
    assert (bus.level === expLevel) else begin
      testsFailed++;
      $error("FAIL %s level observed=%0d expected=%0d", tag, bus.level, expLevel);
    end
    testsRun++;
    assert (bus.rd_data === expData) else begin
      testsFailed++;
      $error("FAIL %s rd_data observed=%02h expected=%02h", tag, bus.rd_data, expData);
    end
    testsRun++;
    assert (bus.empty === (model.size() == 0)) else begin
      testsFailed++;
      $error("FAIL %s empty observed=%b expected=%b", tag, bus.empty, model.size() == 0);
    end
    testsRun++;
    assert (bus.full === (model.size() == DEPTH)) else begin
      testsFailed++;
      $error("FAIL %s full observed=%b expected=%b", tag, bus.full, model.size() == DEPTH);
    end
    testsRun++;
    assert (bus.overflow === modelOvf) else begin
      testsFailed++;
      $error("FAIL %s overflow observed=%b expected=%b", tag, bus.overflow, modelOvf);
    end
    testsRun++;
    assert (bus.irq === expIrq) else begin
      testsFailed++;
      $error("FAIL %s irq observed=%b expected=%b", tag, bus.irq, expIrq);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO rules at the
  // edge, then check just after the edge.
  task automatic applyStimulus(input logic rv, input logic [7:0] b,
                               input logic p, input logic c,
                               input string tag);
    bit doPop;
    bit doPush;
    bus.rx_valid     = rv;
    bus.rx_byte      = b;
    bus.pop          = p;
    bus.clr_overflow = c;
    doPop  = p && (model.size() > 0);
    doPush = rv && ((model.size() < DEPTH) || doPop);
    @(posedge clk);
    if (doPop) void'(model.pop_front());
    if (doPush) model.push_back(b);
    if (rv && !doPush) modelOvf = 1'b1;
    else if (c) modelOvf = 1'b0;
    #1;
    bus.rx_valid     = 1'b0;
    bus.pop          = 1'b0;
    bus.clr_overflow = 1'b0;
    checkOutput(tag);
  endtask

  task automatic applyReset(input logic rv);
    rst          = 1'b1;
    bus.rx_valid = rv;
    bus.rx_byte  = 8'hEE;
    @(posedge clk);
    model.delete();
    modelOvf = 1'b0;
    #1;
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    checkOutput("reset");
  endtask

  initial begin
    rst              = 1'b1;
    bus.rx_valid     = 1'b0;
    bus.rx_byte      = 8'h00;
    bus.pop          = 1'b0;
    bus.clr_overflow = 1'b0;

    // Reset then idle
    applyReset(1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "idle");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "idle");

    // Three bytes with gaps, then three pops and a pop while empty
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, "push41");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "gap");
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, "push42");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "gap");
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b0, "push43");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "pop3");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "popEmpty");

    // Fill, drop one byte, drop with a same-cycle clear, drain, clear
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, "dropAA");
    applyStimulus(1'b1, 8'hAB, 1'b0, 1'b1, "dropWithClr");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "clrOverflow");

    // Push and pop together while full, then while empty
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, "fillRand");
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, "fullPushPop");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain55");
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, "emptyPushPop");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "pop55");

    // Watermark crossing: up to THRESH, down to THRESH-1
    for (int i = 0; i < THRESH; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, "toThresh");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "belowThresh");
    applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, "backAtThresh");

    // Reset mid-operation at level 7 with a byte arriving in that cycle
    applyReset(1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, "toSeven");
    applyReset(1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "postReset");

    // Random traffic: push-heavy, balanced, pop-heavy phases
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 120; i++) begin
        logic rv;
        logic p;
        logic c;
        rv = ($urandom_range(0, 9) < 7 - 2 * phase);
        p  = ($urandom_range(0, 9) < 3 + 2 * phase);
        c  = ($urandom_range(0, 15) == 0);
        applyStimulus(rv, 8'($urandom), p, c, "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
